mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//  Shares a single multi-cycle FP32 multiplier (mul) between N_REQ requesters using round-robin arbitration.
//  mul has no input strobe: it samples its operands in every get_in state. This block therefore holds mul in reset while idle.
//  Each job: latch operands, release mul from reset, wait for its one-cycle output strobe, route the result to the granted requester.
//  A watchdog returns an error response if mul never strobes.
// PARAMETERS
//  N_REQ    4    number of requesters (>=2)
//  TIMEOUT  255  max RUN cycles before error; must be >=12
//  TW       8    timer width; 2**TW > TIMEOUT
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         async, active-low reset
//  req_valid   in   N_REQ     per-requester request
//  req_ready   out  N_REQ     one-hot grant; accept = req_valid[i] & req_ready[i]
//  req_a       in   32*N_REQ  operand A, requester i at [32i+31:32i]
//  req_b       in   32*N_REQ  operand B, same packing
//  resp_valid  out  N_REQ     one-cycle result pulse to owner; no backpressure
//  resp_data   out  32        result, valid while any resp_valid bit is set
//  resp_err    out  1         qualifies resp_valid: 1 = watchdog timeout
//  busy        out  1         job in flight (state RUN)
//  mul_a       out  32        to mul input_a, registered
//  mul_b       out  32        to mul input_b, registered
//  mul_rst     out  1         to mul rst (sync, active-high)
//  mul_z       in   32        from mul output_z
//  mul_z_stb   in   1         from mul output_z_stb
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values: state=IDLE, mul_rst=1, req_ready=0, resp_valid=0, resp_err=0.
//   resp_data=0, mul_a=0, mul_b=0, busy=0, timer=0, last_grant=N_REQ-1.
//  States:
//   IDLE: mul_rst=1.
//    req_ready is combinational: one-hot on the first req_valid bit, searching upward from last_grant+1 with wrap.
//    req_ready is 0 when no requests are present.
//    On accept edge: latch req_a/req_b of winner into mul_a/mul_b; owner<=i; last_grant<=i.
//    Same edge: timer<=0, mul_rst<=0, ->RUN.
//   RUN: req_ready=0; busy=1. Checks each edge, in priority order:
//    1. mul_z_stb=1: resp_data<=mul_z, resp_valid[owner]<=1, resp_err<=0, mul_rst<=1, ->IDLE.
//    2. timer==TIMEOUT: resp_data<=32'h7FC00000, resp_valid[owner]<=1, resp_err<=1, mul_rst<=1, ->IDLE.
//    3. otherwise timer<=timer+1.
//   A strobe coinciding with timeout counts as success (priority 1 wins).
//  resp_valid/resp_err are high for exactly one cycle, then cleared. resp_data holds its value until the next response.
//  mul_rst stays high for at least one edge between jobs, so each job's get_in samples the new operands.
//  mul_z_stb in IDLE is ignored. mul_a/mul_b stay stable throughout RUN.
//  A requester may drop req_valid before it is granted; nothing is accepted and no state changes.
//  Fairness: a requester still asserting req_valid waits at most N_REQ-1 jobs.
//  Reset mid-RUN: immediate return to reset values; mul_rst=1 aborts mul; in-flight job dropped, no response.
//  Latency accept edge -> resp_valid high: 13 cycles for 1.0*1.0. On timeout: TIMEOUT+1 cycles.
//  Back-to-back: next accept possible in the cycle after resp_valid rises.
// TESTING
//  1. req0: 0x3F800000*0x3F800000 -> resp_valid[0] 13 cycles after accept; data 0x3F800000, err 0.
//  2. req1: 0x40000000*0x40400000 -> resp_valid[1] only; data 0x40C00000; other resp_valid bits stay 0.
//  3. All 4 requesting from reset -> grant order 0,1,2,3. Then only 0 and 2 held -> alternation 0,2,0,2.
//  4. Bench mul model never strobes, TIMEOUT=16 -> resp_err=1, data 0x7FC00000, 17 cycles after accept, mul_rst=1.
//  5. rst low 5 cycles into RUN -> all outputs at reset values; no response; next request served correctly.
//  6. 0x7F800000*0x00000000 -> data 0xFFC00000; strobe arriving together with timer==TIMEOUT -> err 0.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Requester-side bus of mul_arbiter: per-requester request/grant with
// packed operands, plus the shared one-cycle response channel.
interface mul_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [32*N_REQ-1:0] req_a;
   logic [32*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]    resp_valid;
   logic [31:0]         resp_data;
   logic                resp_err;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one multi-cycle FP32 multiplier between requesters.
// Ports: clk; rst (async, active-low); bus (requester side, slave modport);
//        busy (job in flight); mul_a/mul_b/mul_rst drive the multiplier;
//        mul_z/mul_z_stb return its result and one-cycle strobe.
module mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic         clk,
   input  logic         rst,
   mul_arbiter_if.slave bus,
   output logic         busy,
   output logic [31:0]  mul_a,
   output logic [31:0]  mul_b,
   output logic         mul_rst,
   input  logic [31:0]  mul_z,
   input  logic         mul_z_stb
);
   localparam int IW = $clog2(N_REQ);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [IW-1:0]    last_grant;
   logic [IW-1:0]    owner;
   logic [IW-1:0]    win;
   logic [TW-1:0]    timer;
   logic [N_REQ-1:0] grant;
   logic             found;

   // Search upward from the requester after the last winner, wrapping.
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         automatic int idx = (int'(last_grant) + k) % N_REQ;
         if (!found && bus.req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = IW'(idx);
         end
      end
   end

   // Gated by rst so no grant is offered while reset is held.
   assign bus.req_ready = (rst && state == IDLE) ? grant : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         mul_rst        <= 1'b1;
         bus.resp_valid <= '0;
         bus.resp_err   <= 1'b0;
         bus.resp_data  <= '0;
         mul_a          <= '0;
         mul_b          <= '0;
         busy           <= 1'b0;
         timer          <= '0;
         owner          <= '0;
         last_grant     <= IW'(N_REQ - 1);
      end else begin
         bus.resp_valid <= '0;
         bus.resp_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  mul_a      <= bus.req_a[32*win +: 32];
                  mul_b      <= bus.req_b[32*win +: 32];
                  owner      <= win;
                  last_grant <= win;
                  timer      <= '0;
                  mul_rst    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // A strobe on the timeout cycle still counts as success.
               if (mul_z_stb) begin
                  bus.resp_data         <= mul_z;
                  bus.resp_valid[owner] <= 1'b1;
                  bus.resp_err          <= 1'b0;
                  mul_rst               <= 1'b1;
                  busy                  <= 1'b0;
                  state                 <= IDLE;
               end else if (timer == TW'(TIMEOUT)) begin
                  bus.resp_data         <= QNAN;
                  bus.resp_valid[owner] <= 1'b1;
                  bus.resp_err          <= 1'b1;
                  mul_rst               <= 1'b1;
                  busy                  <= 1'b0;
                  state                 <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: stub multiplier with programmable latency,
// job-level reference model, directed pins and randomized traffic.
module tb_mul_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        busy;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_rst;
   logic [31:0] mul_z;
   logic        mul_z_stb;
   int          lat;

   int checks = 0;
   int errors = 0;

   mul_arbiter_if #(.N_REQ(N)) bus ();

   mul_arbiter #(
      .N_REQ  (N),
      .TIMEOUT(TO),
      .TW     (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_rst  (mul_rst),
      .mul_z    (mul_z),
      .mul_z_stb(mul_z_stb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mul_fn(logic [31:0] a, logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h3F80_0000;
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
      if (a == 32'h7F80_0000 && b == 32'h0000_0000) return 32'hFFC0_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
   endfunction

   // Stub multiplier: result strobes 'lat' edges after the accept edge;
   // lat==0 never strobes.
   int cnt;
   int job_lat;
   always_ff @(posedge clk) begin
      if (mul_rst) begin
         cnt       <= 0;
         mul_z_stb <= 1'b0;
         job_lat   <= lat;
      end else begin
         cnt       <= cnt + 1;
         mul_z_stb <= (job_lat != 0) && (cnt == job_lat - 2);
         if (job_lat != 0 && cnt == job_lat - 2)
            mul_z <= mul_fn(mul_a, mul_b);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Reference model: jobs as (owner, response edge, data, err).
   bit          m_busy;
   int          m_last;
   int          m_owner;
   int          m_el;
   int          m_at;
   logic [31:0] m_data;
   logic        m_err;
   logic [N-1:0] e_valid;
   logic        e_err;
   logic [31:0] e_data;
   logic        e_busy;
   logic        e_mrst;
   logic [31:0] e_a;
   logic [31:0] e_b;

   task automatic m_reset();
      m_busy  = 0;
      m_last  = N - 1;
      e_valid = '0;
      e_err   = 1'b0;
      e_data  = '0;
      e_busy  = 1'b0;
      e_mrst  = 1'b1;
      e_a     = '0;
      e_b     = '0;
   endtask

   task automatic m_step(int w);
      e_valid = '0;
      e_err   = 1'b0;
      if (m_busy) begin
         m_el++;
         if (m_el == m_at) begin
            e_valid[m_owner] = 1'b1;
            e_err  = m_err;
            e_data = m_data;
            e_mrst = 1'b1;
            e_busy = 1'b0;
            m_busy = 0;
         end
      end else if (w >= 0) begin
         m_owner = w;
         m_last  = w;
         e_a     = bus.req_a[32*w +: 32];
         e_b     = bus.req_b[32*w +: 32];
         m_busy  = 1;
         m_el    = 0;
         e_busy  = 1'b1;
         e_mrst  = 1'b0;
         if (lat != 0 && lat <= TO + 1) begin
            m_at   = lat;
            m_data = mul_fn(e_a, e_b);
            m_err  = 1'b0;
         end else begin
            m_at   = TO + 1;
            m_data = 32'h7FC0_0000;
            m_err  = 1'b1;
         end
      end
   endtask

   initial begin
      int w;
      logic [N-1:0] e_ready;
      m_reset();
      forever begin
         @(negedge clk);
         if (!rst) m_reset();
         chk("resp_valid", 32'(bus.resp_valid), 32'(e_valid));
         chk("resp_err", 32'(bus.resp_err), 32'(e_err));
         chk("resp_data", bus.resp_data, e_data);
         chk("busy", 32'(busy), 32'(e_busy));
         chk("mul_rst", 32'(mul_rst), 32'(e_mrst));
         chk("mul_a", mul_a, e_a);
         chk("mul_b", mul_b, e_b);
         w = (!rst || m_busy) ? -1 : rr_pick(bus.req_valid, m_last);
         e_ready = (w < 0) ? '0 : (N'(1) << w);
         chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
         if (rst) m_step(w);
      end
   end

   task automatic job(input int i, input logic [31:0] a, input logic [31:0] b,
                      input int l, output int n, output logic [N-1:0] v,
                      output logic [31:0] d, output logic e, output logic mr);
      lat = l;
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
      bus.req_valid = N'(1) << i;
      @(posedge clk);
      #2 bus.req_valid = '0;
      n  = 0;
      v  = '0;
      d  = '0;
      e  = 1'b0;
      mr = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.resp_valid != '0) begin
            v  = bus.resp_valid;
            d  = bus.resp_data;
            e  = bus.resp_err;
            mr = mul_rst;
            break;
         end
      end
   endtask

   int gq[$];

   task automatic collect(int upto);
      for (int c = 0; c < 400 && gq.size() < upto; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) gq.push_back(i);
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 60 && busy; c++) @(posedge clk);
      #2;
   endtask

   initial begin
      int n;
      logic [N-1:0] v;
      logic [31:0] d;
      logic e;
      logic mr;
      bit seen;
      int r;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      lat = 13;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mul_rst", 32'(mul_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      job(0, 32'h3F80_0000, 32'h3F80_0000, 13, n, v, d, e, mr);
      chk("t1_latency", n, 13);
      chk("t1_valid", 32'(v), 32'h1);
      chk("t1_data", d, 32'h3F80_0000);
      chk("t1_err", 32'(e), 32'd0);

      job(1, 32'h4000_0000, 32'h4040_0000, 13, n, v, d, e, mr);
      chk("t2_valid", 32'(v), 32'h2);
      chk("t2_data", d, 32'h40C0_0000);

      job(2, 32'h4000_0000, 32'h3F80_0000, 0, n, v, d, e, mr);
      chk("t4_latency", n, 17);
      chk("t4_err", 32'(e), 32'd1);
      chk("t4_data", d, 32'h7FC0_0000);
      chk("t4_mul_rst", 32'(mr), 32'd1);

      job(3, 32'h7F80_0000, 32'h0000_0000, 13, n, v, d, e, mr);
      chk("t6_data", d, 32'hFFC0_0000);
      job(0, 32'h3F80_0000, 32'h3F80_0000, 17, n, v, d, e, mr);
      chk("t6_edge_latency", n, 17);
      chk("t6_edge_err", 32'(e), 32'd0);
      chk("t6_edge_data", d, 32'h3F80_0000);

      lat = 13;
      bus.req_valid = 4'b0100;
      @(posedge clk);
      #2 bus.req_valid = '0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_mul_rst", 32'(mul_rst), 32'd1);
      chk("t5_mul_a", mul_a, 32'd0);
      chk("t5_resp_data", bus.resp_data, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid != '0) seen = 1;
      end
      chk("t5_no_resp", 32'(seen), 32'd0);
      #1;
      job(1, 32'h4000_0000, 32'h4040_0000, 13, n, v, d, e, mr);
      chk("t5_after_valid", 32'(v), 32'h2);
      chk("t5_after_data", d, 32'h40C0_0000);

      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      lat = 13;
      bus.req_valid = 4'hF;
      collect(4);
      @(posedge clk);
      #2 bus.req_valid = 4'b0101;
      collect(8);
      @(posedge clk);
      #2 bus.req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         int exp_g [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
         chk($sformatf("t3_grant%0d", k),
             (k < gq.size()) ? gq[k] : -1, exp_g[k]);
      end
      wait_idle();

      repeat (3000) begin
         @(posedge clk);
         #2;
         rst = ($urandom_range(0, 399) != 0);
         bus.req_valid = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
         bus.req_a = {$urandom, $urandom, $urandom, $urandom};
         bus.req_b = {$urandom, $urandom, $urandom, $urandom};
         r = $urandom_range(0, 19);
         if (r == 0) lat = 0;
         else if (r == 19) lat = 25;
         else if (r >= 17) lat = 13;
         else lat = r + 1;
      end
      rst = 1'b1;
      bus.req_valid = '0;
      wait_idle();
      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
